alu_op_stage: RTL and testbench
===============================

Name: alu_op_stage

Overview:
- Operation sequencer and result hold stage wrapped around the combinational ALU.
- Accepts one ALU request per handshake and latches operands into AI/BI hold registers.
- Drives the ALU's one-hot select lines, captures the ALU result into the ADD hold register, applies the decimal adjust the ALU lacks, and computes N/Z/C/V with a flag write mask.
- Presents the result to the register-file/status writeback under a valid/ready handshake.

Parameters:
- None. The datapath is fixed at 8 bits.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  request valid
- IN_READY  out  1  stage can accept a request
- IN_OP  in  3  000 ADC, 001 SBC, 010 AND, 011 ORA, 100 EOR, 101 ASL, 110 LSR, 111 ROR
- IN_A  in  8  operand A (accumulator or memory)
- IN_B  in  8  operand B
- IN_C  in  1  current carry flag
- IN_D  in  1  current decimal flag
- ALU_A  out  8  to ALU input A
- ALU_B  out  8  to ALU input B
- SUMS, ANDS, ORS, EORS, SRS  out  1 each  ALU operation selects, one-hot
- BCDS  out  1  ALU BCD select
- ALU_CIN  out  1  ALU carry in
- ALU_RESULT  in  8  ALU result
- ALU_OF  in  1  ALU overflow
- ALU_COUT  in  1  ALU carry out
- ALU_HCOUT  in  1  ALU half carry (bit 3 to bit 4)
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts the result
- OUT_RESULT  out  8  final result
- OUT_FLAGS  out  4  {N, Z, C, V}
- OUT_FLAG_WE  out  4  per-flag write enable {N, Z, C, V}

Behaviour:
- Clock and reset: one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All hold registers, OUT_*, ALU_*, selects and BCDS are 0.
  - IN_READY is 1 once reset is released.
- IN_READY = (state == IDLE). A request is accepted on a rising edge with IN_VALID & IN_READY; at that edge op, A, B, C and D are latched.
- FSM states: IDLE, EXEC, ADJ, DONE.
  - IDLE -> EXEC on accept.
  - EXEC -> ADJ if D latched and op is ADC or SBC; otherwise EXEC -> DONE. On the EXEC exit edge, capture ALU_RESULT, ALU_COUT, ALU_HCOUT and ALU_OF into hold registers.
  - ADJ -> DONE, always after 1 cycle.
  - DONE -> IDLE on OUT_READY.
- Latency: OUT_VALID rises 2 cycles after the accept edge for binary ops, 3 cycles for decimal ADC/SBC.
- OUT_VALID = (state == DONE). OUT_* are stable while OUT_VALID is 1 and OUT_READY is 0. There is no same-cycle re-accept: IN_READY is 0 in DONE.
- ALU drive:
  - Select lines are asserted only in EXEC; they are 0 in all other states.
  - ALU_A and ALU_B hold the latched operands from accept until the next accept.
  - ADC: SUMS; A, B; CIN = C.
  - SBC: SUMS; A, ~B; CIN = C.
  - AND, ORA, EOR: ANDS, ORS, EORS respectively.
  - ASL: SUMS; ALU_A = ALU_B = A; CIN = 0.
  - LSR and ROR: SRS; ALU_A = A.
  - BCDS = D & (ADC | SBC), driven in EXEC only.
- Result and flags (R is the captured ALU_RESULT):
  - ROR: result = {C_latched, R[6:0]}; C = ALU_COUT.
  - LSR: result = R; C = ALU_COUT.
  - ASL, ADC, SBC (binary): result = R; C = ALU_COUT; V = ALU_OF for ADC/SBC.
  - Logic ops: result = R; C and V outputs carry the latched C and 0 but are masked off.
  - N = result[7] and Z = (result == 0), both taken from the final (adjusted) result.
- OUT_FLAG_WE:
  - Logic ops: 1100.
  - Shifts: 1110.
  - ADC/SBC: 1111.
- Decimal adjust in ADJ. S is the 9-bit value {ALU_COUT, R}.
  - ADC:
    - If HCOUT or R[3:0] > 9, then S = S + 6.
    - If ALU_COUT or S > 0x99, then S = S + 0x60 and C = 1; else C = 0.
    - Result = S[7:0].
  - SBC:
    - If !HCOUT, then low nibble = low nibble - 6 (4-bit wrap, no borrow into the high nibble).
    - If !ALU_COUT, then high nibble = high nibble - 6.
    - C = ALU_COUT.
  - V is always the binary ALU_OF.
- Reset mid-operation: abandon immediately. OUT_VALID drops asynchronously; no partial result is ever presented.
- IN_* changes while the stage is not in IDLE are ignored.

Decomposition:
- Shared package alu_pkg:
  - op code constants (ADC..ROR, 3 bits)
  - state encoding
  - flag bit indices N=3, Z=2, C=1, V=0
  - BCD constants 6, 0x60, 0x99
- Sub-module alu_bcd_adjust: combinational. Inputs op, R, Cout, HCout; outputs result and C. The FSM, hold registers and flag logic stay in alu_op_stage.
- The ALU itself is modelled in the bench and instantiated alongside the stage, not inside it.

Test Plan:
- ADC binary, A=0x50, B=0x50, C=0, D=0 -> RESULT 0xA0, FLAGS N1 Z0 C0 V1, WE 1111, OUT_VALID 2 cycles after accept.
- ADC decimal, A=0x58, B=0x46, C=1, D=1 (ALU gives 0x9F, HC0, C0) -> RESULT 0x05, C1, Z0, OUT_VALID after 3 cycles.
- SBC decimal, A=0x12, B=0x21, C=1, D=1 (ALU_B must show 0xDE; ALU gives 0xF1, C0, HC1) -> RESULT 0x91, C0, N1.
- ROR, A=0x01, C=1 -> RESULT 0x80, FLAGS N1 Z0 C1, WE 1110. AND, A=0xF0, B=0x0F -> RESULT 0x00, Z1, WE 1100.
- Back-pressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 and new data -> OUT_* constant, IN_READY 0, new request accepted only on the first IDLE cycle.
- Assert RST_N=0 while in EXEC -> OUT_VALID, selects and outputs 0 without a clock edge. After release, IN_READY=1 and a fresh ADC 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation stage: op codes, FSM encoding,
// flag bit positions and decimal-adjust constants.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADC = 3'b000,
        OP_SBC = 3'b001,
        OP_AND = 3'b010,
        OP_ORA = 3'b011,
        OP_EOR = 3'b100,
        OP_ASL = 3'b101,
        OP_LSR = 3'b110,
        OP_ROR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ADJ  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_NIBBLE_ADJ = 4'd6;
    localparam logic [9:0] BCD_LO_ADJ     = 10'h006;
    localparam logic [9:0] BCD_HI_ADJ     = 10'h060;
    localparam logic [9:0] BCD_BYTE_MAX   = 10'h099;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_bcd_adjust.sv
// Decimal correction applied to a captured binary ADC/SBC result, since the
// ALU itself only produces binary sums.
module alu_bcd_adjust
    import alu_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] r,
    input  logic       cout,
    input  logic       hcout,
    output logic [7:0] result,
    output logic       c
);

    logic [9:0] s;
    logic [3:0] lo;
    logic [3:0] hi;

    always_comb begin
        s      = {2'b00, cout, r};
        lo     = r[3:0];
        hi     = r[7:4];
        result = r;
        c      = cout;
        if (op == OP_ADC) begin
            if (hcout || (r[3:0] > BCD_DIGIT_MAX)) begin
                s = s + BCD_LO_ADJ;
            end
            // High-digit decision looks at the value after the low-digit fix
            if (cout || (s > BCD_BYTE_MAX)) begin
                s = s + BCD_HI_ADJ;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            result = s[7:0];
        end else if (op == OP_SBC) begin
            if (!hcout) begin
                lo = lo - BCD_NIBBLE_ADJ;
            end
            if (!cout) begin
                hi = hi - BCD_NIBBLE_ADJ;
            end
            result = {hi, lo};
            c      = cout;
        end
    end

endmodule

// File: rtl/alu_op_stage.sv
// Sequencer and result-hold stage around the external combinational ALU:
// latches a request, drives the ALU, captures and decimal-adjusts, presents flags.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// EXEC  | ALU selects driven, result captured on exit
// ADJ   | decimal correction of a captured ADC/SBC result
// DONE  | result and flags presented until out_ready
module alu_op_stage
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_c,
    input  logic       in_d,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       sums,
    output logic       ands,
    output logic       ors,
    output logic       eors,
    output logic       srs,
    output logic       bcds,
    output logic       alu_cin,
    input  logic [7:0] alu_result,
    input  logic       alu_of,
    input  logic       alu_cout,
    input  logic       alu_hcout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [3:0] out_flags,
    output logic [3:0] out_flag_we
);

    state_e     state_q, state_d;
    op_e        op_q;
    logic       c_q, d_q;
    logic [7:0] alu_a_q, alu_b_q;
    logic       alu_cin_q;
    logic [7:0] r_q;
    logic       cout_q, hc_q, of_q;
    logic [7:0] bcd_result;
    logic       bcd_c;
    logic       accept;
    logic [7:0] res_fin;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_cin  = alu_cin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sums    = 1'b0;
        ands    = 1'b0;
        ors     = 1'b0;
        eors    = 1'b0;
        srs     = 1'b0;
        bcds    = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = (d_q && is_arith(op_q)) ? ST_ADJ : ST_DONE;
                bcds    = d_q && is_arith(op_q);
                case (op_q)
                    OP_ADC, OP_SBC, OP_ASL: sums = 1'b1;
                    OP_AND:                 ands = 1'b1;
                    OP_ORA:                 ors  = 1'b1;
                    OP_EOR:                 eors = 1'b1;
                    default:                srs  = 1'b1;
                endcase
            end
            ST_ADJ:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADC;
            c_q       <= 1'b0;
            d_q       <= 1'b0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_cin_q <= 1'b0;
            r_q       <= 8'h00;
            cout_q    <= 1'b0;
            hc_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(in_op);
                c_q     <= in_c;
                d_q     <= in_d;
                alu_a_q <= in_a;
                case (op_e'(in_op))
                    OP_ADC: begin alu_b_q <= in_b;  alu_cin_q <= in_c; end
                    OP_SBC: begin alu_b_q <= ~in_b; alu_cin_q <= in_c; end
                    OP_ASL: begin alu_b_q <= in_a;  alu_cin_q <= 1'b0; end
                    default: begin alu_b_q <= in_b; alu_cin_q <= 1'b0; end
                endcase
            end
            if (state_q == ST_EXEC) begin
                r_q    <= alu_result;
                cout_q <= alu_cout;
                hc_q   <= alu_hcout;
                of_q   <= alu_of;
            end
            // Decimal result overwrites the binary capture; V keeps the binary ALU_OF
            if (state_q == ST_ADJ) begin
                r_q    <= bcd_result;
                cout_q <= bcd_c;
            end
        end
    end

    alu_bcd_adjust u_bcd (
        .op     (op_q),
        .r      (r_q),
        .cout   (cout_q),
        .hcout  (hc_q),
        .result (bcd_result),
        .c      (bcd_c)
    );

    assign res_fin = (op_q == OP_ROR) ? {c_q, r_q[6:0]} : r_q;

    always_comb begin
        out_valid   = 1'b0;
        out_result  = 8'h00;
        out_flags   = 4'b0000;
        out_flag_we = 4'b0000;
        if (state_q == ST_DONE) begin
            out_valid         = 1'b1;
            out_result        = res_fin;
            out_flags[FLAG_N] = res_fin[7];
            out_flags[FLAG_Z] = (res_fin == 8'h00);
            case (op_q)
                OP_ADC, OP_SBC: begin
                    out_flags[FLAG_C] = cout_q;
                    out_flags[FLAG_V] = of_q;
                    out_flag_we       = 4'b1111;
                end
                OP_ASL, OP_LSR, OP_ROR: begin
                    out_flags[FLAG_C] = cout_q;
                    out_flag_we       = 4'b1110;
                end
                default: begin
                    out_flags[FLAG_C] = c_q;
                    out_flag_we       = 4'b1100;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_stage.sv
// Directed bench for alu_op_stage with a behavioural binary ALU attached to
// its drive/return ports.
module tb_alu_op_stage;

    logic       clk, rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic       in_c, in_d;
    logic [7:0] alu_a, alu_b;
    logic       sums, ands, ors, eors, srs, bcds, alu_cin;
    logic [7:0] alu_result;
    logic       alu_of, alu_cout, alu_hcout;
    logic       out_valid, out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags, out_flag_we;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .alu_a(alu_a), .alu_b(alu_b),
        .sums(sums), .ands(ands), .ors(ors), .eors(eors), .srs(srs), .bcds(bcds),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_of(alu_of),
        .alu_cout(alu_cout), .alu_hcout(alu_hcout),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_flag_we(out_flag_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Binary-only ALU, as the hardware has
    logic [8:0] sum9;
    logic [4:0] hsum;
    always_comb begin
        sum9       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
        hsum       = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cin};
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        alu_hcout  = 1'b0;
        alu_of     = 1'b0;
        if (sums) begin
            alu_result = sum9[7:0];
            alu_cout   = sum9[8];
            alu_hcout  = hsum[4];
            alu_of     = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
        end else if (ands) begin
            alu_result = alu_a & alu_b;
        end else if (ors) begin
            alu_result = alu_a | alu_b;
        end else if (eors) begin
            alu_result = alu_a ^ alu_b;
        end else if (srs) begin
            alu_result = {1'b0, alu_a[7:1]};
            alu_cout   = alu_a[0];
        end
    end

    // Presents one request just after an edge and returns #1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic d);
        in_op = op; in_a = a; in_b = b; in_c = c; in_d = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges from the accept edge (inclusive) until out_valid
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic complete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if ({out_result, out_flags, out_flag_we} !== 16'h0000) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0000", {out_result, out_flags, out_flag_we}); end
        n_checks++; if ({alu_a, alu_b, alu_cin} !== 17'h0) begin n_fail++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_a, alu_b, alu_cin}); end
        n_checks++; if ({sums, ands, ors, eors, srs, bcds} !== 6'b0) begin n_fail++; $display("FAIL reset_selects got=%b exp=000000", {sums, ands, ors, eors, srs, bcds}); end
    endtask

    task automatic test_adc_binary();
        int e;
        issue(3'b000, 8'h50, 8'h50, 1'b0, 1'b0);
        n_checks++; if ({sums, ands, ors, eors, srs, bcds} !== 6'b100000) begin n_fail++; $display("FAIL adcb_selects got=%b exp=100000", {sums, ands, ors, eors, srs, bcds}); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL adcb_in_ready got=%b exp=0", in_ready); end
        wait_valid(e);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL adcb_latency got=%0d exp=2", e); end
        n_checks++; if (out_result !== 8'hA0) begin n_fail++; $display("FAIL adcb_result got=%h exp=a0", out_result); end
        n_checks++; if (out_flags !== 4'b1001) begin n_fail++; $display("FAIL adcb_flags got=%b exp=1001", out_flags); end
        n_checks++; if (out_flag_we !== 4'b1111) begin n_fail++; $display("FAIL adcb_we got=%b exp=1111", out_flag_we); end
        n_checks++; if ({sums, ands, ors, eors, srs} !== 5'b0) begin n_fail++; $display("FAIL adcb_done_selects got=%b exp=00000", {sums, ands, ors, eors, srs}); end
        complete();
    endtask

    task automatic test_adc_decimal();
        int e;
        issue(3'b000, 8'h58, 8'h46, 1'b1, 1'b1);
        n_checks++; if ({sums, bcds, alu_cin} !== 3'b111) begin n_fail++; $display("FAIL adcd_drive got=%b exp=111", {sums, bcds, alu_cin}); end
        wait_valid(e);
        n_checks++; if (e !== 3) begin n_fail++; $display("FAIL adcd_latency got=%0d exp=3", e); end
        n_checks++; if (out_result !== 8'h05) begin n_fail++; $display("FAIL adcd_result got=%h exp=05", out_result); end
        n_checks++; if (out_flags !== 4'b0011) begin n_fail++; $display("FAIL adcd_flags got=%b exp=0011", out_flags); end
        complete();
    endtask

    task automatic test_sbc_decimal();
        int e;
        issue(3'b001, 8'h12, 8'h21, 1'b1, 1'b1);
        n_checks++; if (alu_b !== 8'hDE) begin n_fail++; $display("FAIL sbcd_alu_b got=%h exp=de", alu_b); end
        n_checks++; if (alu_cin !== 1'b1) begin n_fail++; $display("FAIL sbcd_cin got=%b exp=1", alu_cin); end
        wait_valid(e);
        n_checks++; if (e !== 3) begin n_fail++; $display("FAIL sbcd_latency got=%0d exp=3", e); end
        n_checks++; if (out_result !== 8'h91) begin n_fail++; $display("FAIL sbcd_result got=%h exp=91", out_result); end
        n_checks++; if (out_flags !== 4'b1000) begin n_fail++; $display("FAIL sbcd_flags got=%b exp=1000", out_flags); end
        complete();
    endtask

    task automatic test_shifts();
        int e;
        issue(3'b111, 8'h01, 8'h00, 1'b1, 1'b0);
        n_checks++; if ({sums, srs} !== 2'b01) begin n_fail++; $display("FAIL ror_selects got=%b exp=01", {sums, srs}); end
        wait_valid(e);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL ror_latency got=%0d exp=2", e); end
        n_checks++; if (out_result !== 8'h80) begin n_fail++; $display("FAIL ror_result got=%h exp=80", out_result); end
        n_checks++; if ((out_flags & 4'b1110) !== 4'b1010) begin n_fail++; $display("FAIL ror_flags got=%b exp=101x", out_flags); end
        n_checks++; if (out_flag_we !== 4'b1110) begin n_fail++; $display("FAIL ror_we got=%b exp=1110", out_flag_we); end
        complete();
        issue(3'b101, 8'h81, 8'h00, 1'b1, 1'b1);
        n_checks++; if ({alu_b, alu_cin, bcds} !== 10'b1000000100) begin n_fail++; $display("FAIL asl_drive got=%b exp=1000000100", {alu_b, alu_cin, bcds}); end
        wait_valid(e);
        n_checks++; if (out_result !== 8'h02) begin n_fail++; $display("FAIL asl_result got=%h exp=02", out_result); end
        n_checks++; if ((out_flags & 4'b1110) !== 4'b0010) begin n_fail++; $display("FAIL asl_flags got=%b exp=001x", out_flags); end
        complete();
    endtask

    task automatic test_logic();
        int e;
        issue(3'b010, 8'hF0, 8'h0F, 1'b1, 1'b1);
        n_checks++; if ({sums, ands, bcds} !== 3'b010) begin n_fail++; $display("FAIL and_selects got=%b exp=010", {sums, ands, bcds}); end
        wait_valid(e);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL and_latency got=%0d exp=2", e); end
        n_checks++; if (out_result !== 8'h00) begin n_fail++; $display("FAIL and_result got=%h exp=00", out_result); end
        n_checks++; if (out_flags !== 4'b0110) begin n_fail++; $display("FAIL and_flags got=%b exp=0110", out_flags); end
        n_checks++; if (out_flag_we !== 4'b1100) begin n_fail++; $display("FAIL and_we got=%b exp=1100", out_flag_we); end
        complete();
        issue(3'b100, 8'hF0, 8'hFF, 1'b0, 1'b0);
        wait_valid(e);
        n_checks++; if ({out_result, out_flags} !== 12'h0F0) begin n_fail++; $display("FAIL eor_result got=%h exp=0f0", {out_result, out_flags}); end
        complete();
    endtask

    task automatic test_back_to_back();
        int e;
        issue(3'b000, 8'h10, 8'h20, 1'b0, 1'b0);
        wait_valid(e);
        in_op = 3'b000; in_a = 8'h01; in_b = 8'h02; in_c = 1'b0; in_d = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if ({out_valid, in_ready, out_result, out_flags, out_flag_we} !== 18'b10_00110000_0000_1111) begin
                n_fail++; $display("FAIL bp_hold cycle=%0d got=%b exp=100011000000001111", i, {out_valid, in_ready, out_result, out_flags, out_flag_we});
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_idle got=%b exp=10", {in_ready, out_valid}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if ({in_ready, alu_a, alu_b} !== 17'h00102) begin n_fail++; $display("FAIL bp_accept got=%h exp=00102", {in_ready, alu_a, alu_b}); end
        wait_valid(e);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", e); end
        n_checks++; if (out_result !== 8'h03) begin n_fail++; $display("FAIL bp_result got=%h exp=03", out_result); end
        complete();
    endtask

    task automatic test_reset_mid();
        int e;
        issue(3'b000, 8'h33, 8'h44, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, sums, alu_a, alu_b} !== 18'h0) begin n_fail++; $display("FAIL rst_exec got=%h exp=0", {out_valid, sums, alu_a, alu_b}); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL rst_exec_after got=%b exp=10", {in_ready, out_valid}); end
        issue(3'b000, 8'h44, 8'h44, 1'b0, 1'b0);
        wait_valid(e);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, out_result, out_flag_we} !== 13'h0) begin n_fail++; $display("FAIL rst_done got=%h exp=0", {out_valid, out_result, out_flag_we}); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'b000, 8'h01, 8'h01, 1'b0, 1'b0);
        wait_valid(e);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL rst_fresh_latency got=%0d exp=2", e); end
        n_checks++; if ({out_result, out_flags} !== 12'h020) begin n_fail++; $display("FAIL rst_fresh_result got=%h exp=020", {out_result, out_flags}); end
        complete();
    endtask

    initial begin
        in_valid = 1'b0; in_op = 3'b000; in_a = 8'h00; in_b = 8'h00;
        in_c = 1'b0; in_d = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
        #1;
        test_reset();
        test_adc_binary();
        test_adc_decimal();
        test_sbc_decimal();
        test_shifts();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
